// File: rtl/systolic_array_pkg.sv
// Shared constants for the output-stationary systolic matrix multiplier.
package systolic_array_pkg;

  localparam int unsigned ACC_WIDTH          = 32;
  localparam int unsigned DEFAULT_M          = 4;
  localparam int unsigned DEFAULT_K          = 4;
  localparam int unsigned DEFAULT_N          = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/systolic_array_if.sv
// Operand/result bundle for the systolic array: the requester drives A/B and observes C/done.
interface systolic_array_if
  import systolic_array_pkg::*;
#(
  parameter int unsigned M          = DEFAULT_M,
  parameter int unsigned K          = DEFAULT_K,
  parameter int unsigned N          = DEFAULT_N,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic signed [DATA_WIDTH-1:0] A [M][K];
  logic signed [DATA_WIDTH-1:0] B [K][N];
  logic signed [ACC_WIDTH-1:0]  C [M][N];
  logic                         done;

  modport master (output A, output B, input C, input done);
  modport slave  (input A, input B, output C, output done);

endinterface

// File: rtl/systolic_pe.sv
// One mesh cell: signed MAC into a wrapping accumulator, with a/b forwarded right/down.
module systolic_pe
  import systolic_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [DATA_WIDTH-1:0] a_o,
  output logic signed [DATA_WIDTH-1:0] b_o,
  output logic signed [ACC_WIDTH-1:0]  acc_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_d, acc_q;
  logic signed [DATA_WIDTH-1:0]   a_q, b_q;

  always_comb begin
    prod  = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);
    acc_d = acc_q + ACC_WIDTH'(prod);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_array.sv
// M x N output-stationary systolic multiplier: C = A * B, operands latched during reset.
module systolic_array
  import systolic_array_pkg::*;
#(
  parameter int unsigned M          = DEFAULT_M,
  parameter int unsigned K          = DEFAULT_K,
  parameter int unsigned N          = DEFAULT_N,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] A [M][K],
  input  logic signed [DATA_WIDTH-1:0] B [K][N],
  output logic signed [ACC_WIDTH-1:0]  C [M][N],
  output logic                         done
);

  localparam int unsigned TLast = M + N + K - 3;
  localparam int unsigned TMax  = M + N + K - 2;
  localparam int unsigned TW    = $clog2(TMax + 1);

  logic [TW-1:0] t_d, t_q;
  logic          done_d, done_q;

  logic signed [DATA_WIDTH-1:0] a_q [M][K];
  logic signed [DATA_WIDTH-1:0] b_q [K][N];
  logic signed [DATA_WIDTH-1:0] a_edge [M];
  logic signed [DATA_WIDTH-1:0] b_edge [N];

  // Horizontal/vertical links; column N and row M are the unused outputs of the last PEs.
  logic signed [DATA_WIDTH-1:0] a_h [M][N+1];
  logic signed [DATA_WIDTH-1:0] b_v [M+1][N];

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= A;
      b_q <= B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_q    <= '0;
      done_q <= 1'b0;
    end else begin
      t_q    <= t_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    t_d    = t_q;
    if (t_q != TW'(TMax)) t_d = t_q + TW'(1);
    done_d = done_q | (t_q == TW'(TLast));
  end

  // Skewed feeders: row i sees A[i][t-i], column j sees B[t-j][j], zero outside the window.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      a_edge[i] = '0;
      for (int k = 0; k < K; k++) begin
        if (t_q == TW'(i + k)) a_edge[i] = a_q[i][k];
      end
    end
    for (int j = 0; j < N; j++) begin
      b_edge[j] = '0;
      for (int k = 0; k < K; k++) begin
        if (t_q == TW'(j + k)) b_edge[j] = b_q[k][j];
      end
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_row_feed
    assign a_h[i][0] = a_edge[i];
  end
  for (genvar j = 0; j < N; j++) begin : g_col_feed
    assign b_v[0][j] = b_edge[j];
  end

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_pe (
        .clk  (clk),
        .reset(reset),
        .a_i  (a_h[i][j]),
        .b_i  (b_v[i][j]),
        .a_o  (a_h[i][j+1]),
        .b_o  (b_v[i+1][j]),
        .acc_o(C[i][j])
      );
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: table of matrix products plus timing/reset sequences.
module tb_systolic_array;
  import systolic_array_pkg::*;

  localparam int unsigned M  = 4;
  localparam int unsigned K  = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  typedef logic signed [DW-1:0]        mat8_t [M][K];
  typedef logic signed [ACC_WIDTH-1:0] mat32_t [M][N];
  typedef struct {
    string  name;
    mat8_t  a;
    mat8_t  b;
    mat32_t c;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_array_if #(.M(M), .K(K), .N(N), .DATA_WIDTH(DW)) mif ();

  systolic_array #(
    .M         (M),
    .K         (K),
    .N         (N),
    .DATA_WIDTH(DW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .A    (mif.A),
    .B    (mif.B),
    .C    (mif.C),
    .done (mif.done)
  );

  vec_t   vecs [4];
  mat8_t  seq_m, ident_m, neg_m, pos_m;
  mat32_t seq_sq, zero_c;
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mat(input string name, input mat32_t exp);
    int bi = -1;
    int bj = -1;
    n_cmp++;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        if (bi < 0 && mif.C[i][j] !== exp[i][j]) begin
          bi = i;
          bj = j;
        end
    if (bi >= 0) begin
      n_err++;
      $display("FAIL %s: C[%0d][%0d] got %0d required %0d", name, bi, bj,
               mif.C[bi][bj], exp[bi][bj]);
    end
  endtask

  task automatic check_val(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_ne(input string name, input longint act, input longint bad);
    n_cmp++;
    if (act == bad) begin
      n_err++;
      $display("FAIL %s: got %0d required anything but %0d", name, act, bad);
    end
  endtask

  task automatic load(input mat8_t a, input mat8_t b);
    mif.A = a;
    mif.B = b;
  endtask

  initial begin
    for (int i = 0; i < M; i++)
      for (int k = 0; k < K; k++) begin
        seq_m[i][k]   = DW'(4 * i + k + 1);
        ident_m[i][k] = (i == k) ? 8'sd1 : 8'sd0;
        neg_m[i][k]   = -8'sd128;
        pos_m[i][k]   = 8'sd127;
      end
    seq_sq = '{'{90, 100, 110, 120}, '{202, 228, 254, 280},
               '{314, 356, 398, 440}, '{426, 484, 542, 600}};
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) zero_c[i][j] = '0;

    vecs[0].name = "seq_x_seq";
    vecs[0].a = seq_m;  vecs[0].b = seq_m;   vecs[0].c = seq_sq;
    vecs[1].name = "seq_x_ident";
    vecs[1].a = seq_m;  vecs[1].b = ident_m;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) vecs[1].c[i][j] = 32'(4 * i + j + 1);
    vecs[2].name = "neg_x_neg";
    vecs[2].a = neg_m;  vecs[2].b = neg_m;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) vecs[2].c[i][j] = 32'sd65536;
    vecs[3].name = "neg_x_pos";
    vecs[3].a = neg_m;  vecs[3].b = pos_m;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) vecs[3].c[i][j] = -32'sd65024;

    // Long reset holds everything at zero.
    reset = 1'b1;
    load(seq_m, seq_m);
    for (int c = 0; c < 3; c++) begin
      step();
      check_mat("reset_hold_c", zero_c);
      check_val("reset_hold_done", longint'(mif.done), 0);
    end

    for (int v = 0; v < 4; v++) begin
      load(vecs[v].a, vecs[v].b);
      reset = 1'b1;
      step();
      check_mat({vecs[v].name, "_reset_c"}, zero_c);
      reset = 1'b0;
      repeat (10) step();
      check_mat(vecs[v].name, vecs[v].c);
      check_val({vecs[v].name, "_done"}, longint'(mif.done), 1);
    end

    // Completion lands exactly on edge t=9.
    load(seq_m, seq_m);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      if (e < 9) begin
        check_ne("early_c33", longint'(mif.C[3][3]), 600);
        check_val("early_done", longint'(mif.done), 0);
      end else begin
        check_val("final_c33", longint'(mif.C[3][3]), 600);
        check_val("final_done", longint'(mif.done), 1);
      end
    end

    // Port changes after completion must not disturb the result.
    load(neg_m, pos_m);
    repeat (20) step();
    check_mat("hold_after_done", seq_sq);
    check_val("hold_done", longint'(mif.done), 1);

    // Mid-run reset aborts and restarts.
    load(seq_m, seq_m);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    check_mat("abort_c", zero_c);
    check_val("abort_done", longint'(mif.done), 0);
    reset = 1'b0;
    repeat (9) step();
    check_val("restart_not_done", longint'(mif.done), 0);
    step();
    check_mat("restart_c", seq_sq);
    check_val("restart_done", longint'(mif.done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
